// File: rtl/sd_spi_cmd_engine_if.sv
// Command/response bundle for the SD SPI command engine.
// Engine side uses the slave modport, host side the master modport.
interface sd_spi_cmd_engine_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;
   logic        cmd_long;
   logic        init_done;
   logic        resp_valid;
   logic [7:0]  resp_r1;
   logic [31:0] resp_data;
   logic        resp_timeout;

   modport master (
      output cmd_valid, cmd_index, cmd_arg, cmd_long,
      input  cmd_ready, init_done, resp_valid,
      input  resp_r1, resp_data, resp_timeout
   );

   modport slave (
      input  cmd_valid, cmd_index, cmd_arg, cmd_long,
      output cmd_ready, init_done, resp_valid,
      output resp_r1, resp_data, resp_timeout
   );
endinterface

// File: rtl/sd_spi_cmd_engine.sv
// SD card SPI-mode command engine: power-up clocks, framed
// command with CRC7, R1 wait with timeout, optional 4-byte tail.
module sd_spi_cmd_engine #(
   parameter int CLK_DIV      = 125,
   parameter int INIT_CLOCKS  = 80,
   parameter int RESP_TIMEOUT = 8
) (
   input  logic               CLOCK_50,
   input  logic               KEY0,
   sd_spi_cmd_engine_if.slave bus,
   output logic               sd_sclk,
   output logic               sd_mosi,
   input  logic               sd_miso,
   output logic               sd_cs_n
);

   typedef enum logic [2:0] {
      ST_INIT, ST_IDLE, ST_PRE, ST_SEND,
      ST_WAIT_R1, ST_READ_EXT, ST_TAIL, ST_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] div_q, div_d;
   logic        sclk_q, sclk_d;
   logic        mosi_q, mosi_d;
   logic        cs_n_q, cs_n_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  byte_q, byte_d;
   logic [47:0] frame_q, frame_d;
   logic        long_q, long_d;
   logic [6:0]  rx_q, rx_d;
   logic [7:0]  pr1_q, pr1_d;
   logic [31:0] pdata_q, pdata_d;
   logic        pto_q, pto_d;
   logic [7:0]  r1_q, r1_d;
   logic [31:0] data_q, data_d;
   logic        to_q, to_d;
   logic        init_done_q, init_done_d;
   logic        miso_s1_q, miso_s2_q;

   logic        run, tick, fall;
   logic [7:0]  rx_byte;
   logic [5:0]  nxt_bit;
   logic [39:0] hdr;

   function automatic logic [6:0] crc7(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = 7'd0;
      for (int i = 39; i >= 0; i--) begin
         fb = d[i] ^ c[6];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   assign run = state_q inside {ST_INIT, ST_PRE, ST_SEND,
                                ST_WAIT_R1, ST_READ_EXT, ST_TAIL};
   assign tick    = (div_q == 16'(CLK_DIV - 1));
   // Every bit boundary (shift, sample, count) is the falling edge.
   assign fall    = run && tick && sclk_q;
   assign rx_byte = {rx_q, miso_s2_q};
   assign nxt_bit = 6'd46 - cnt_q[5:0];
   assign hdr     = {2'b01, bus.cmd_index, bus.cmd_arg};

   assign bus.cmd_ready    = (state_q == ST_IDLE);
   assign bus.resp_valid   = (state_q == ST_DONE);
   assign bus.init_done    = init_done_q;
   assign bus.resp_r1      = r1_q;
   assign bus.resp_data    = data_q;
   assign bus.resp_timeout = to_q;
   assign sd_sclk = sclk_q;
   assign sd_mosi = mosi_q;
   assign sd_cs_n = cs_n_q;

   // State, divider, shift and response registers; reset reruns power-up.
   always_ff @(posedge CLOCK_50 or negedge KEY0) begin
      if (!KEY0) begin
         state_q     <= ST_INIT;
         div_q       <= '0;
         sclk_q      <= 1'b0;
         mosi_q      <= 1'b1;
         cs_n_q      <= 1'b1;
         cnt_q       <= '0;
         byte_q      <= '0;
         frame_q     <= '0;
         long_q      <= 1'b0;
         rx_q        <= '0;
         pr1_q       <= 8'hFF;
         pdata_q     <= '0;
         pto_q       <= 1'b0;
         r1_q        <= 8'hFF;
         data_q      <= '0;
         to_q        <= 1'b0;
         init_done_q <= 1'b0;
         miso_s1_q   <= 1'b1;
         miso_s2_q   <= 1'b1;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         sclk_q      <= sclk_d;
         mosi_q      <= mosi_d;
         cs_n_q      <= cs_n_d;
         cnt_q       <= cnt_d;
         byte_q      <= byte_d;
         frame_q     <= frame_d;
         long_q      <= long_d;
         rx_q        <= rx_d;
         pr1_q       <= pr1_d;
         pdata_q     <= pdata_d;
         pto_q       <= pto_d;
         r1_q        <= r1_d;
         data_q      <= data_d;
         to_q        <= to_d;
         init_done_q <= init_done_d;
         miso_s1_q   <= sd_miso;
         miso_s2_q   <= miso_s1_q;
      end
   end

   // Next-state logic; miso is taken at the falling edge, which is the
   // rising-edge value delayed by the two-flop synchroniser.
   always_comb begin
      state_d     = state_q;
      div_d       = '0;
      sclk_d      = 1'b0;
      mosi_d      = mosi_q;
      cs_n_d      = cs_n_q;
      cnt_d       = cnt_q;
      byte_d      = byte_q;
      frame_d     = frame_q;
      long_d      = long_q;
      rx_d        = rx_q;
      pr1_d       = pr1_q;
      pdata_d     = pdata_q;
      pto_d       = pto_q;
      r1_d        = r1_q;
      data_d      = data_q;
      to_d        = to_q;
      init_done_d = init_done_q;

      if (run) begin
         div_d  = tick ? 16'd0 : div_q + 16'd1;
         sclk_d = tick ? ~sclk_q : sclk_q;
      end

      unique case (state_q)
         ST_INIT: if (fall) begin
            if (cnt_q == 16'(INIT_CLOCKS - 1)) begin
               state_d     = ST_IDLE;
               cnt_d       = '0;
               init_done_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_IDLE: if (bus.cmd_valid) begin
            frame_d = {hdr, crc7(hdr), 1'b1};
            long_d  = bus.cmd_long;
            state_d = ST_PRE;
            cs_n_d  = 1'b0;
            mosi_d  = 1'b1;
            cnt_d   = '0;
         end
         ST_PRE: if (fall) begin
            if (cnt_q == 16'd7) begin
               state_d = ST_SEND;
               cnt_d   = '0;
               mosi_d  = frame_q[47];
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_SEND: if (fall) begin
            if (cnt_q == 16'd47) begin
               state_d = ST_WAIT_R1;
               cnt_d   = '0;
               byte_d  = '0;
               mosi_d  = 1'b1;
            end else begin
               cnt_d  = cnt_q + 16'd1;
               mosi_d = frame_q[nxt_bit];
            end
         end
         ST_WAIT_R1: if (fall) begin
            rx_d = rx_byte[6:0];
            if (cnt_q == 16'd7) begin
               cnt_d = '0;
               if (!rx_byte[7]) begin
                  pr1_d   = rx_byte;
                  pto_d   = 1'b0;
                  pdata_d = '0;
                  if (long_q) begin
                     state_d = ST_READ_EXT;
                  end else begin
                     state_d = ST_TAIL;
                     cs_n_d  = 1'b1;
                  end
               end else if (byte_q == 8'(RESP_TIMEOUT - 1)) begin
                  pr1_d   = 8'hFF;
                  pto_d   = 1'b1;
                  pdata_d = '0;
                  state_d = ST_TAIL;
                  cs_n_d  = 1'b1;
               end else if (byte_q != 8'hFF) begin
                  byte_d = byte_q + 8'd1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_READ_EXT: if (fall) begin
            pdata_d = {pdata_q[30:0], miso_s2_q};
            if (cnt_q == 16'd31) begin
               state_d = ST_TAIL;
               cnt_d   = '0;
               cs_n_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_TAIL: if (fall) begin
            if (cnt_q == 16'd7) begin
               state_d = ST_DONE;
               cnt_d   = '0;
               r1_d    = pr1_q;
               data_d  = pdata_q;
               to_d    = pto_q;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_INIT;
      endcase
   end

endmodule

// File: doc/sd_spi_cmd_engine.md
SD_SPI_CMD_ENGINE -- requirements
Module: sd_spi_cmd_engine

Interface
REQ-001 SHALL have parameter CLK_DIV, default 125, CLOCK_50 cycles per SCLK half-period; legal range 2..65535.
REQ-002 SHALL have parameter INIT_CLOCKS, default 80, number of power-up SCLK pulses.
REQ-003 SHALL have parameter RESP_TIMEOUT, default 8, maximum response-wait bytes; legal range 1..255.
REQ-004 CLOCK_50  in  1  sole clock; all logic on its rising edge.
REQ-005 KEY0  in  1  reset, asynchronous assert, active-low.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  engine idle, can accept a command.
REQ-008 cmd_index  in  6  SD command index.
REQ-009 cmd_arg  in  32  command argument.
REQ-010 cmd_long  in  1  1 = R3/R7 response, 4 bytes after R1.
REQ-011 init_done  out  1  power-up clocks complete; stays high until reset.
REQ-012 resp_valid  out  1  one-cycle pulse, response fields valid.
REQ-013 resp_r1  out  8  R1 byte.
REQ-014 resp_data  out  32  trailing bytes, first received in [31:24].
REQ-015 resp_timeout  out  1  no R1 within RESP_TIMEOUT bytes; qualified by resp_valid.
REQ-016 sd_sclk  out  1  SPI clock, idle low (mode 0).
REQ-017 sd_mosi  out  1  SPI data to card.
REQ-018 sd_miso  in  1  SPI data from card; two-flop synchronised before use.
REQ-019 sd_cs_n  out  1  card select, active-low.

Function
REQ-020 SHALL implement states INIT, IDLE, PRE, SEND, WAIT_R1, READ_EXT, TAIL, DONE.
REQ-021 INIT: sd_cs_n=1, sd_mosi=1, exactly INIT_CLOCKS SCLK pulses; then init_done=1 and go to IDLE.
REQ-022 SCLK: toggles every CLK_DIV cycles only in INIT, PRE, SEND, WAIT_R1, READ_EXT, TAIL; held low in IDLE and DONE.
REQ-023 Bit timing: sd_mosi updates on SCLK falling edge (first bit before first rising edge); sd_miso sampled on SCLK rising edge.
REQ-024 cmd_ready=1 only in IDLE; handshake on cmd_valid&&cmd_ready; index, arg and long latched that cycle; cmd_ready=0 from the next cycle.
REQ-025 cmd_valid outside IDLE SHALL be ignored; latched fields SHALL NOT change mid-command.
REQ-026 PRE: sd_cs_n=0, one 0xFF byte (8 pulses).
REQ-027 SEND: 48-bit frame MSB first = {2'b01, index, arg, crc7, 1'b1}.
REQ-028 crc7 over the first 40 frame bits, polynomial x^7+x^3+1, register init 0, computed before or during SEND without extra SCLK pulses.
REQ-029 WAIT_R1: sd_mosi=1, clock byte-wise; first byte with bit7=0 is R1.
REQ-030 If RESP_TIMEOUT bytes pass without R1: resp_r1=8'hFF, resp_timeout=1, resp_data=0, skip READ_EXT.
REQ-031 READ_EXT (cmd_long=1 and R1 found): clock 4 more bytes into resp_data.
REQ-032 TAIL: sd_cs_n=1, sd_mosi=1, 8 SCLK pulses.
REQ-033 DONE: resp_valid=1 for exactly one cycle, then IDLE with cmd_ready=1 the following cycle.
REQ-034 resp_r1, resp_data and resp_timeout SHALL hold their values until the next DONE.
REQ-035 Byte counters SHALL saturate and not wrap; R1 on the final allowed byte is a success, not a timeout.

Reset
REQ-036 KEY0 low SHALL immediately force INIT with counters cleared and outputs set to: cmd_ready=0, init_done=0, resp_valid=0, resp_r1=8'hFF, resp_data=0, resp_timeout=0, sd_sclk=0, sd_mosi=1, sd_cs_n=1.
REQ-037 Reset mid-command SHALL abort with no resp_valid; the power-up sequence reruns after release.

Verification
REQ-038 Reset release, CLK_DIV=2 -> exactly 80 sd_sclk rising edges with sd_cs_n=1, then init_done=1 and cmd_ready=1.
REQ-039 CMD0 arg 0 -> sd_mosi frame 40 00 00 00 00 95; card model returns 0x01 on byte 2 -> resp_valid pulse, resp_r1=0x01, resp_timeout=0.
REQ-040 CMD8 arg 0x000001AA, cmd_long=1 -> frame 48 00 00 01 AA 87; model returns 01 00 00 01 AA -> resp_r1=0x01, resp_data=0x000001AA.
REQ-041 Model holds sd_miso=1 -> exactly RESP_TIMEOUT wait bytes, resp_timeout=1, resp_r1=0xFF, then 8 TAIL pulses.
REQ-042 KEY0 pulsed low during SEND -> sd_cs_n=1 and sd_sclk=0 at once, no resp_valid, 80 init pulses repeated.
REQ-043 cmd_valid held high through DONE -> exactly one new command accepted per IDLE entry; no command lost or duplicated.
